// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-file slave: FSM encoding,
// default geometry and the byte-strobe merge used by the register array.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_WAIT_STATES = 0;

  // The merge works on the widest supported word; callers zero-extend and
  // truncate, which keeps one function usable for every DATA_WIDTH.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x DATA_WIDTH register array with a byte-strobed write port, a
// combinational read port and a view of the post-merge write word.
module apb_regfile_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [ADDR_WIDTH-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   wr_word
);

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]     mem_d [DEPTH];
  logic [DATA_WIDTH-1:0]     old_word;
  logic [MAX_DATA_WIDTH-1:0] old_ext;
  logic [MAX_DATA_WIDTH-1:0] new_ext;
  logic [MAX_STRB_WIDTH-1:0] strb_ext;
  logic [MAX_DATA_WIDTH-1:0] merged_ext;

  // Index decode by comparison so an index wider than the array needs no
  // out-of-range select; indices >= DEPTH simply match nothing.
  always_comb begin
    old_word = '0;
    rd_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_idx == ADDR_WIDTH'(i)) old_word = mem_q[i];
      if (rd_idx == ADDR_WIDTH'(i)) rd_data  = mem_q[i];
    end
  end

  always_comb begin
    old_ext  = '0;
    new_ext  = '0;
    strb_ext = '0;
    old_ext[DATA_WIDTH-1:0]    = old_word;
    new_ext[DATA_WIDTH-1:0]    = wdata;
    strb_ext[DATA_WIDTH/8-1:0] = wstrb;
    merged_ext = strb_merge(old_ext, new_ext, strb_ext);
    wr_word    = merged_ext[DATA_WIDTH-1:0];
  end

  if (DATA_WIDTH < MAX_DATA_WIDTH) begin : g_hi
    logic unused_merge_hi;
    assign unused_merge_hi = ^merged_ext[MAX_DATA_WIDTH-1:DATA_WIDTH];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (we && (wr_idx == ADDR_WIDTH'(i))) ? wr_word : mem_q[i];
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: setup/wait/done FSM, wait counter, range error and
// write-notify port. Define APB_SLV_PSTRB_EN to add the pstrb byte-lane port.
module apb_regfile_slave
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    wr_pulse,
  output logic [ADDR_WIDTH-1:0]   wr_idx,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [1:0]              dbg_state
);

  // Handshake: a transfer starts with a setup cycle (psel=1, penable=0) and
  // completes in the cycle pready=1; pslverr and read data are only
  // meaningful in that cycle. Dropping psel during wait cycles aborts it.

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic                    wr_pulse_q, wr_pulse_d;
  logic [ADDR_WIDTH-1:0]   wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                    setup;
  logic                    setup_err;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic [DATA_WIDTH-1:0]   mem_wr_word;
  logic [DATA_WIDTH/8-1:0] wstrb;

`ifdef APB_SLV_PSTRB_EN
  assign wstrb = pstrb;
`else
  assign wstrb = '1;
`endif

  assign setup     = psel & ~penable;
  assign setup_err = {1'b0, paddr} >= DEPTH_L;
  assign commit    = (state_q == DONE) & write_q & ~err_q & psel & penable;
  // With no wait states the read happens on the setup edge, before the latch.
  assign rd_idx    = (state_q == IDLE) ? paddr : addr_q;

  apb_regfile_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .pclk    (pclk),
    .preset_n(preset_n),
    .we      (commit),
    .wr_idx  (addr_q),
    .wdata   (pwdata),
    .wstrb   (wstrb),
    .rd_idx  (rd_idx),
    .rd_data (mem_rd_data),
    .wr_word (mem_wr_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    prdata_d   = prdata_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = paddr;
          write_d = pwrite;
          err_d   = setup_err;
          if (WAIT_STATES == 0) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = setup_err ? '0 : mem_rd_data;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = DONE;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = err_q ? '0 : mem_rd_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (commit) begin
          wr_pulse_d = 1'b1;
          wr_idx_d   = addr_q;
          wr_data_d  = mem_wr_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      wr_pulse_q <= wr_pulse_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_idx    = wr_idx_q;
  assign wr_data   = wr_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave using three instances:
// 0: DEPTH=24 WAIT_STATES=0, 1: DEPTH=32 WAIT_STATES=3, 2: DEPTH=32 WAIT_STATES=2.
module tb_apb_regfile_slave;

  logic        pclk;
  logic        preset_n;
  logic        psel_v    [3];
  logic        penable_v [3];
  logic        pwrite_v  [3];
  logic [5:0]  paddr_v   [3];
  logic [31:0] pwdata_v  [3];
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb_v   [3];
`endif
  logic [31:0] prdata_v  [3];
  logic        pready_v  [3];
  logic        pslverr_v [3];
  logic        wr_pulse_v[3];
  logic [5:0]  wr_idx_v  [3];
  logic [31:0] wr_data_v [3];
  logic [1:0]  dbg_v     [3];

  int checks   = 0;
  int failures = 0;

  int          pulse_cnt [3] = '{0, 0, 0};
  logic [5:0]  last_idx  [3] = '{6'd0, 6'd0, 6'd0};
  logic [31:0] last_data [3] = '{32'd0, 32'd0, 32'd0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_regfile_slave #(
      .ADDR_WIDTH (6),
      .DATA_WIDTH (32),
      .DEPTH      ((g == 0) ? 24 : 32),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .psel     (psel_v[g]),
      .penable  (penable_v[g]),
      .pwrite   (pwrite_v[g]),
      .paddr    (paddr_v[g]),
      .pwdata   (pwdata_v[g]),
`ifdef APB_SLV_PSTRB_EN
      .pstrb    (pstrb_v[g]),
`endif
      .prdata   (prdata_v[g]),
      .pready   (pready_v[g]),
      .pslverr  (pslverr_v[g]),
      .wr_pulse (wr_pulse_v[g]),
      .wr_idx   (wr_idx_v[g]),
      .wr_data  (wr_data_v[g]),
      .dbg_state(dbg_v[g])
    );
  end

  // Clock and reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Notify-port monitor
  always @(negedge pclk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_pulse_v[k] === 1'b1) begin
        pulse_cnt[k]++;
        last_idx[k]  = wr_idx_v[k];
        last_data[k] = wr_data_v[k];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Driver: one complete APB transfer on instance k, leaving the bus so the
  // next call can start its setup cycle immediately (back-to-back).
  task automatic apb_xfer(input int k, input logic wr, input logic [5:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int acc_cycles);
    logic done;
    psel_v[k]    = 1'b1;
    penable_v[k] = 1'b0;
    pwrite_v[k]  = wr;
    paddr_v[k]   = addr;
    pwdata_v[k]  = data;
`ifdef APB_SLV_PSTRB_EN
    pstrb_v[k]   = strb;
`else
    if (strb != 4'hF) $display("note: strobe 0x%h ignored without pstrb port", strb);
`endif
    @(posedge pclk);
    #1 penable_v[k] = 1'b1;
    acc_cycles = 0;
    rdata = '0;
    err = 1'b0;
    done = 1'b0;
    while (!done && acc_cycles < 20) begin
      @(negedge pclk);
      acc_cycles++;
      if (pready_v[k] === 1'b1) begin
        rdata = prdata_v[k];
        err   = pslverr_v[k];
        done  = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout: inst %0d addr %0d pready not seen in %0d cycles, required within 20", k, addr, acc_cycles);
    end
    @(posedge pclk);
    #1;
    psel_v[k]    = 1'b0;
    penable_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      psel_v[k] = 1'b0; penable_v[k] = 1'b0; pwrite_v[k] = 1'b0;
      paddr_v[k] = '0; pwdata_v[k] = '0;
`ifdef APB_SLV_PSTRB_EN
      pstrb_v[k] = 4'hF;
`endif
    end
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({prdata_v[k], pready_v[k], pslverr_v[k], wr_pulse_v[k], wr_idx_v[k], wr_data_v[k], dbg_v[k]} !== 76'd0) begin
        failures++;
        $display("FAIL reset_outputs: inst %0d prdata=%h pready=%b pslverr=%b wr_pulse=%b wr_idx=%0d wr_data=%h state=%0d, required all 0",
                 k, prdata_v[k], pready_v[k], pslverr_v[k], wr_pulse_v[k], wr_idx_v[k], wr_data_v[k], dbg_v[k]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int cyc; int base;
    base = pulse_cnt[0];
    apb_xfer(0, 1'b1, 6'd3, 32'hDEADBEEF, 4'hF, rd, err, cyc);
    checks++;
    if (cyc !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL wr3_resp: cycles=%0d pslverr=%b, required 1 and 0", cyc, err);
    end
    apb_xfer(0, 1'b0, 6'd3, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (cyc !== 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL rd3_resp: cycles=%0d pslverr=%b, required 1 and 0", cyc, err);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd3_data: got %h, required deadbeef", rd);
    end
    checks++;
    if (pulse_cnt[0] !== base + 1 || last_idx[0] !== 6'd3 || last_data[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr3_notify: pulses=%0d idx=%0d data=%h, required %0d 3 deadbeef",
               pulse_cnt[0] - base, last_idx[0], last_data[0], 1);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int cyc;
    apb_xfer(1, 1'b0, 6'd0, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (cyc !== 4 || err !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL ws3_read0: cycles=%0d pslverr=%b data=%h, required 4 0 00000000", cyc, err, rd);
    end
    apb_xfer(1, 1'b1, 6'd31, 32'hA5A50F0F, 4'hF, rd, err, cyc);
    apb_xfer(1, 1'b0, 6'd31, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (cyc !== 4 || err !== 1'b0 || rd !== 32'hA5A50F0F) begin
      failures++;
      $display("FAIL ws3_last_idx: cycles=%0d pslverr=%b data=%h, required 4 0 a5a50f0f", cyc, err, rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int cyc; int base;
    base = pulse_cnt[0];
    apb_xfer(0, 1'b1, 6'd30, 32'h00001234, 4'hF, rd, err, cyc);
    checks++;
    if (err !== 1'b1 || cyc !== 1) begin
      failures++;
      $display("FAIL oor_wr_err: pslverr=%b cycles=%0d, required 1 and 1", err, cyc);
    end
    apb_xfer(0, 1'b0, 6'd30, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL oor_rd: pslverr=%b data=%h, required 1 00000000", err, rd);
    end
    @(posedge pclk); #1;
    checks++;
    if (pulse_cnt[0] !== base) begin
      failures++;
      $display("FAIL oor_no_pulse: pulses=%0d, required 0", pulse_cnt[0] - base);
    end
    apb_xfer(0, 1'b0, 6'd6, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      failures++;
      $display("FAIL oor_alias6: data=%h pslverr=%b, required 00000000 0", rd, err);
    end
    apb_xfer(0, 1'b0, 6'd3, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL oor_keep3: data=%h, required deadbeef", rd);
    end
    apb_xfer(0, 1'b1, 6'd23, 32'h00005A5A, 4'hF, rd, err, cyc);
    apb_xfer(0, 1'b0, 6'd23, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h00005A5A || err !== 1'b0) begin
      failures++;
      $display("FAIL last_valid23: data=%h pslverr=%b, required 00005a5a 0", rd, err);
    end
    apb_xfer(0, 1'b0, 6'd24, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      failures++;
      $display("FAIL first_invalid24: data=%h pslverr=%b, required 00000000 1", rd, err);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int cyc; int base;
    apb_xfer(0, 1'b1, 6'd5, 32'hFFFFFFFF, 4'hF, rd, err, cyc);
`ifdef APB_SLV_PSTRB_EN
    apb_xfer(0, 1'b1, 6'd5, 32'h00000000, 4'b0101, rd, err, cyc);
    @(posedge pclk); #1;
    checks++;
    if (err !== 1'b0 || last_data[0] !== 32'hFF00FF00) begin
      failures++;
      $display("FAIL strb_wr_data: pslverr=%b wr_data=%h, required 0 ff00ff00", err, last_data[0]);
    end
    apb_xfer(0, 1'b0, 6'd5, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'hFF00FF00) begin
      failures++;
      $display("FAIL strb_read: data=%h, required ff00ff00", rd);
    end
    base = pulse_cnt[0];
    apb_xfer(0, 1'b1, 6'd5, 32'h12345678, 4'b0000, rd, err, cyc);
    @(posedge pclk); #1;
    checks++;
    if (err !== 1'b0 || cyc !== 1 || pulse_cnt[0] !== base + 1 || last_data[0] !== 32'hFF00FF00) begin
      failures++;
      $display("FAIL strb_zero: pslverr=%b cycles=%0d pulses=%0d wr_data=%h, required 0 1 1 ff00ff00",
               err, cyc, pulse_cnt[0] - base, last_data[0]);
    end
    apb_xfer(0, 1'b0, 6'd5, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'hFF00FF00) begin
      failures++;
      $display("FAIL strb_zero_keep: data=%h, required ff00ff00", rd);
    end
`else
    apb_xfer(0, 1'b1, 6'd5, 32'h00000000, 4'hF, rd, err, cyc);
    @(posedge pclk); #1;
    base = pulse_cnt[0];
    checks++;
    if (last_idx[0] !== 6'd5 || last_data[0] !== 32'h0) begin
      failures++;
      $display("FAIL full_wr_data: wr_idx=%0d wr_data=%h, required 5 00000000", last_idx[0], last_data[0]);
    end
    apb_xfer(0, 1'b0, 6'd5, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h0 || pulse_cnt[0] !== base) begin
      failures++;
      $display("FAIL full_word_read: data=%h extra_pulses=%0d, required 00000000 0", rd, pulse_cnt[0] - base);
    end
`endif
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; int base; logic saw_ready;
    base = pulse_cnt[2];
    saw_ready = 1'b0;
    psel_v[2] = 1'b1; penable_v[2] = 1'b0; pwrite_v[2] = 1'b1;
    paddr_v[2] = 6'd7; pwdata_v[2] = 32'hCAFEF00D;
    @(posedge pclk);
    #1 penable_v[2] = 1'b1;
    @(negedge pclk);
    if (pready_v[2] !== 1'b0) saw_ready = 1'b1;
    @(posedge pclk);
    #1 psel_v[2] = 1'b0; penable_v[2] = 1'b0;
    @(negedge pclk);
    if (pready_v[2] !== 1'b0) saw_ready = 1'b1;
    @(negedge pclk);
    if (pready_v[2] !== 1'b0) saw_ready = 1'b1;
    checks++;
    if (dbg_v[2] !== 2'b00 || saw_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: state=%0d pready_seen=%b, required 0 0", dbg_v[2], saw_ready);
    end
    apb_xfer(2, 1'b0, 6'd7, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h0 || cyc !== 3 || pulse_cnt[2] !== base) begin
      failures++;
      $display("FAIL abort_no_write: data=%h cycles=%0d pulses=%0d, required 00000000 3 0", rd, cyc, pulse_cnt[2] - base);
    end
    apb_xfer(2, 1'b1, 6'd7, 32'h00000011, 4'hF, rd, err, cyc);
    apb_xfer(2, 1'b0, 6'd7, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h00000011 || cyc !== 3) begin
      failures++;
      $display("FAIL ws2_after_abort: data=%h cycles=%0d, required 00000011 3", rd, cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc; int base;
    base = pulse_cnt[0];
    psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
    paddr_v[0] = 6'd1; pwdata_v[0] = 32'h00000077;
    @(posedge pclk);
    #1 penable_v[0] = 1'b1;
    #1;
    checks++;
    if (pready_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_ready: pready=%b, required 1", pready_v[0]);
    end
    preset_n = 1'b0;
    #1;
    checks++;
    if ({prdata_v[0], pready_v[0], pslverr_v[0], wr_pulse_v[0], wr_idx_v[0], wr_data_v[0], dbg_v[0]} !== 76'd0) begin
      failures++;
      $display("FAIL midrst_outputs: prdata=%h pready=%b pslverr=%b wr_pulse=%b wr_idx=%0d wr_data=%h state=%0d, required all 0",
               prdata_v[0], pready_v[0], pslverr_v[0], wr_pulse_v[0], wr_idx_v[0], wr_data_v[0], dbg_v[0]);
    end
    psel_v[0] = 1'b0; penable_v[0] = 1'b0;
    @(posedge pclk);
    #1 preset_n = 1'b1;
    apb_xfer(0, 1'b0, 6'd1, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h0 || pulse_cnt[0] !== base) begin
      failures++;
      $display("FAIL midrst_no_write: data=%h pulses=%0d, required 00000000 0", rd, pulse_cnt[0] - base);
    end
    apb_xfer(0, 1'b0, 6'd3, 32'h0, 4'hF, rd, err, cyc);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL midrst_cleared3: data=%h, required 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_range();
    test_strobe();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB slave register file: the next generation of the team's single-width APB memory slave. Adds configurable depth, data width, programmable wait states, `pslverr` on out-of-range access, optional byte strobes, and a one-cycle write-notify side port. It sits behind the APB interconnect as a generic control/status register bank for peripheral blocks.

## Interface
- `ADDR_WIDTH`, 6: word-index address width; `paddr` selects a word, not a byte.
- `DATA_WIDTH`, 32: register width; must be a multiple of 8.
- `DEPTH`, 32: number of implemented registers, 1..2**ADDR_WIDTH.
- `WAIT_STATES`, 0: wait cycles inserted in every access phase, 0..15.
- `pclk` in 1: APB clock, all logic on rising edge.
- `preset_n` in 1: reset, asynchronous, active-low.
- `psel` in 1: slave select.
- `penable` in 1: access-phase indicator.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_WIDTH: word index.
- `pwdata` in DATA_WIDTH: write data.
- `pstrb` in DATA_WIDTH/8: byte-lane write enables; present only with `APB_SLV_PSTRB_EN`.
- `prdata` out DATA_WIDTH: read data, valid while `pready`=1 on a read.
- `pready` out 1: transfer completes this cycle.
- `pslverr` out 1: error response, valid only while `pready`=1.
- `wr_pulse` out 1: one-cycle pulse after each committed write.
- `wr_idx` out ADDR_WIDTH: index of the committed write.
- `wr_data` out DATA_WIDTH: full register value after the write, including merged bytes.

## Operation
- FSM `state_t` has three states: IDLE, WAIT, DONE.
- IDLE, setup cycle seen (`psel`=1, `penable`=0):
  - Latch `paddr`, `pwrite`, and `err = (paddr >= DEPTH)`.
  - WAIT_STATES=0: go to DONE.
  - Otherwise: go to WAIT and load `cnt = WAIT_STATES-1`.
- WAIT:
  - `psel`=0: abort to IDLE. No write, no response.
  - `cnt`=0: go to DONE.
  - Otherwise: decrement `cnt`.
- Read data is loaded on the edge that enters DONE:
  - `err`=1: `prdata` = 0.
  - Otherwise: `prdata` = mem[latched addr].
- DONE:
  - `pready`=1 and `pslverr`=`err`, both registered.
  - On the DONE edge, a write with `err`=0 and `psel`&`penable`&`pwrite` commits to mem.
  - The FSM always returns to IDLE.
- Back-to-back transfers: the cycle after DONE may be a new setup cycle, and IDLE detects it.
- Out-of-range write: no storage change, no `wr_pulse`, `pslverr`=1.
- Registers are flops, cleared to 0 by reset.
- `prdata` holds its last value outside DONE. Checkers look at it only when `pready`=1.
- `pready` and `pslverr` are 0 in IDLE and WAIT.

## Timing
- Reset values: `prdata`, `pready`, `pslverr`, `wr_pulse`, `wr_idx`, `wr_data`, all registers and `cnt` are 0; the FSM is in IDLE.
- Transfer length is `2 + WAIT_STATES` cycles: setup, then `WAIT_STATES` wait cycles, then the DONE cycle.
- Write-to-read on the same register with back-to-back transfers returns the new value.
- `wr_pulse`, `wr_idx` and `wr_data` are driven on the cycle after the DONE cycle, for one cycle.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0, no partial write.
- `paddr`, `pwrite` and `pwdata` changing after setup (protocol violation):
  - Address and direction come from the setup latch.
  - `pwdata` and `pstrb` are sampled at the DONE edge.

## Configuration
- `APB_SLV_PSTRB_EN` defined:
  - The `pstrb` port exists.
  - Byte lane i is written only if `pstrb[i]`=1; other lanes are kept.
  - A write with `pstrb`=0 completes with `pready` and no error, changes nothing, and still pulses `wr_pulse`.
- `APB_SLV_PSTRB_EN` undefined:
  - No `pstrb` port.
  - Every write updates the full word.

## Structure
- Package `apb_slave_pkg` holds:
  - `state_t`, encoded IDLE=2'b00, WAIT=2'b01, DONE=2'b10.
  - Default width constants.
  - A `strb_merge` function (old word, new word, strobes → merged word).
- One sub-module, `apb_regfile_mem`:
  - DEPTH×DATA_WIDTH flop array with async reset.
  - Strobed write port and combinational read port.
- The top level holds the FSM, the wait counter, error decode and the notify registers.

## Test plan
- Reset, then write 0xDEADBEEF to idx 3, then read idx 3 (WAIT_STATES=0) → `pready` in the 2nd cycle of each transfer, `prdata`=0xDEADBEEF, `pslverr`=0, one `wr_pulse` with `wr_idx`=3.
- WAIT_STATES=3, read idx 0 → `pready` low for 3 access cycles, high on the 4th, `prdata`=0.
- DEPTH=24: write 0x1234 to idx 30, then read idx 30 → `pslverr`=1 on both, `prdata`=0, no `wr_pulse`, other registers unchanged.
- `APB_SLV_PSTRB_EN`: write 0xFFFFFFFF to idx 5, then write 0x00000000 with `pstrb`=4'b0101 → read returns 0xFF00FF00, `wr_data`=0xFF00FF00.
- WAIT_STATES=2: `psel` dropped during a wait cycle of a write to idx 7 → FSM back in IDLE, `pready` never 1, idx 7 still 0.
- `preset_n` pulsed in the access phase of a write to idx 1 → all outputs 0 immediately, idx 1 reads 0 afterwards.
